// File: rtl/ap_pkg.sv
// Shared definitions for the saturating adder/subtractor family: FSM state encoding
// and width-derived saturation limits.
package ap_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } ap_state_e;

    localparam int unsigned DefaultBitlap = 16;

    // Limits as 64-bit patterns; callers truncate to their own width.
    function automatic logic [63:0] sat_max(int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/ap_sub_accum_if.sv
// Operand stream, result handshake and control signals of the subtract-accumulator.
interface ap_sub_accum_if #(
    parameter int unsigned BITLAP = 16
);
    logic              start;
    logic [BITLAP-1:0] init;
    logic              in_valid;
    logic              in_ready;
    logic [BITLAP-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [BITLAP-1:0] out_data;
    logic              out_sat;
    logic              busy;

    modport master (
        output start, init, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );

    modport slave (
        input  start, init, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/ap_subtractor.sv
// Combinational saturating subtract z = sat(x - y) on two's complement operands.
module ap_subtractor
    import ap_pkg::*;
#(
    parameter int unsigned BITLAP = DefaultBitlap
) (
    input  logic [BITLAP-1:0] x,
    input  logic [BITLAP-1:0] y,
    output logic [BITLAP-1:0] z,
    output logic              ovf
);
    localparam int unsigned       Msb = BITLAP - 1;
    localparam logic [BITLAP-1:0] Max = BITLAP'(sat_max(BITLAP));
    localparam logic [BITLAP-1:0] Min = BITLAP'(sat_min(BITLAP));

    logic [BITLAP-1:0] t;
    logic              pos_o;
    logic              neg_o;

    always_comb begin
        t     = x - y;
        // Overflow only when operand signs differ and the wrapped result flips sign.
        pos_o = !x[Msb] &  y[Msb] &  t[Msb];
        neg_o =  x[Msb] & !y[Msb] & !t[Msb];
        ovf   = pos_o | neg_o;
        if (pos_o) begin
            z = Max;
        end else if (neg_o) begin
            z = Min;
        end else begin
            z = t;
        end
    end

endmodule

// File: rtl/ap_sub_accum.sv
// Streaming saturating subtract-accumulator: acc = init - sum(in_data), clamped each step,
// result and sticky saturation flag returned over a valid/ready handshake.
module ap_sub_accum
    import ap_pkg::*;
#(
    parameter int unsigned BITLAP = DefaultBitlap
) (
    input logic            clk,
    input logic            rst_n,
    ap_sub_accum_if.slave  bus
);
    ap_state_e         state_q, state_d;
    logic [BITLAP-1:0] acc_q, acc_d;
    logic              sat_q, sat_d;
    logic [BITLAP-1:0] step_z;
    logic              step_ovf;
    logic              in_ready;
    logic              beat;

    ap_subtractor #(
        .BITLAP (BITLAP)
    ) u_sub (
        .x   (acc_q),
        .y   (bus.in_data),
        .z   (step_z),
        .ovf (step_ovf)
    );

    assign beat = bus.in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (beat && bus.in_last) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (state_q == StIdle && bus.start) begin
            acc_d = bus.init;
            sat_d = 1'b0;
        end else if (beat) begin
            acc_d = step_z;
            sat_d = sat_q | step_ovf;
        end
    end

    // Outputs decode from registered state only; result fields read as zero outside DONE.
    always_comb begin
        in_ready      = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        bus.out_data  = '0;
        bus.out_sat   = 1'b0;
        unique case (state_q)
            StRun: begin
                in_ready = 1'b1;
                bus.busy = 1'b1;
            end
            StDone: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                bus.out_data  = acc_q;
                bus.out_sat   = sat_q;
            end
            default: ;
        endcase
    end

    assign bus.in_ready = in_ready;

endmodule

// File: tb/tb_ap_sub_accum.sv
// Directed bench for ap_sub_accum at BITLAP = 8: vector table plus handshake corner cases.
module tb_ap_sub_accum;
    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ap_sub_accum_if #(.BITLAP(W)) bus ();

    ap_sub_accum #(
        .BITLAP (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    init;
        int    n;
        int    d0;
        int    d1;
        int    d2;
        int    exp_data;
        int    exp_sat;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input int init, input int n, input int d0,
                                input int d1, input int d2, input int ed, input int es);
        vec_t v;
        v.name = name; v.init = init; v.n = n;
        v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.exp_data = ed; v.exp_sat = es;
        return v;
    endfunction

    function automatic int beat_of(input vec_t v, input int i);
        case (i)
            0:       return v.d0;
            1:       return v.d1;
            default: return v.d2;
        endcase
    endfunction

    function automatic int sdata();
        return int'($signed(bus.out_data));
    endfunction

    task automatic start_acc(input int init);
        bus.start = 1'b1;
        bus.init  = W'(init);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input int d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = W'(d);
        bus.in_last  = last;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic finish_result(input string name);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({name, ".idle_valid"}, int'(bus.out_valid), 0);
        chk({name, ".idle_busy"}, int'(bus.busy), 0);
    endtask

    task automatic run_vec(input vec_t v);
        chk({v.name, ".pre_ready"}, int'(bus.in_ready), 0);
        start_acc(v.init);
        chk({v.name, ".run_ready"}, int'(bus.in_ready), 1);
        chk({v.name, ".run_busy"}, int'(bus.busy), 1);
        for (int i = 0; i < v.n; i++) begin
            send(beat_of(v, i), i == v.n - 1);
        end
        chk({v.name, ".out_valid"}, int'(bus.out_valid), 1);
        chk({v.name, ".done_ready"}, int'(bus.in_ready), 0);
        chk({v.name, ".out_data"}, sdata(), v.exp_data);
        chk({v.name, ".out_sat"}, int'(bus.out_sat), v.exp_sat);
        finish_result(v.name);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.init      = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0]  = mk("basic",     10,   3, 3,   4,   2, 1,    0);
        vecs[1]  = mk("pos_clamp", 100,  2, -50, 20,  0, 107,  1);
        vecs[2]  = mk("pos_first", 100,  1, -50, 0,   0, 127,  1);
        vecs[3]  = mk("neg_clamp", -100, 1, 100, 0,   0, -128, 1);
        vecs[4]  = mk("min_edge",  0,    1, -128, 0,  0, 127,  1);
        vecs[5]  = mk("neg_wrap",  -128, 1, 1,   0,   0, -128, 1);
        vecs[6]  = mk("max_hold",  127,  1, -1,  0,   0, 127,  1);
        vecs[7]  = mk("exact_min", -1,   1, 127, 0,   0, -128, 0);
        vecs[8]  = mk("zero",      0,    1, 0,   0,   0, 0,    0);
        vecs[9]  = mk("mixed",     50,   2, 20,  -30, 0, 60,   0);
        vecs[10] = mk("neg_minus_min", -1, 1, -128, 0, 0, 127, 0);

        #12;
        chk("reset.in_ready", int'(bus.in_ready), 0);
        chk("reset.out_valid", int'(bus.out_valid), 0);
        chk("reset.out_data", sdata(), 0);
        chk("reset.busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: DONE must hold while start and beats are pulsed.
        start_acc(20);
        send(5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus.start    = 1'b1;
            bus.init     = W'(99);
            bus.in_valid = 1'(i % 2);
            bus.in_data  = W'(3);
            bus.in_last  = 1'b1;
            tick();
            chk("bp.out_valid", int'(bus.out_valid), 1);
            chk("bp.out_data", sdata(), 15);
            chk("bp.out_sat", int'(bus.out_sat), 0);
            chk("bp.in_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk("bp.handshake_valid", int'(bus.out_valid), 0);
        chk("bp.start_ignored", int'(bus.in_ready), 0);
        start_acc(1);
        chk("bp.restart_ready", int'(bus.in_ready), 1);
        send(1, 1'b1);
        chk("bp.restart_data", sdata(), 0);
        finish_result("bp");

        // Gapped input: idle cycles must not disturb acc.
        start_acc(5);
        send(1, 1'b0);
        bus.in_data = W'(99);
        tick();
        tick();
        chk("gap.hold_ready", int'(bus.in_ready), 1);
        chk("gap.hold_valid", int'(bus.out_valid), 0);
        send(1, 1'b1);
        chk("gap.out_valid", int'(bus.out_valid), 1);
        chk("gap.out_data", sdata(), 3);
        finish_result("gap");

        // Asynchronous reset mid-stream, then a fresh accumulation.
        start_acc(50);
        send(10, 1'b0);
        send(10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.in_ready", int'(bus.in_ready), 0);
        chk("rst.out_valid", int'(bus.out_valid), 0);
        chk("rst.out_data", sdata(), 0);
        chk("rst.out_sat", int'(bus.out_sat), 0);
        chk("rst.busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = W'(10);
        bus.in_last  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("rst.needs_start", int'(bus.in_ready), 0);
        chk("rst.no_done", int'(bus.out_valid), 0);
        run_vec(mk("post_rst", 7, 1, 7, 0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
